// File: rtl/unidade_controle_multiciclo.sv
// Multicycle processor control unit.
// Sequences fetch, decode, execute, memory and write-back. Drives the datapath
// enables and the memory request handshake. A watchdog aborts a memory access
// that waits too long for mem_pronto.
module unidade_controle_multiciclo #(
    parameter int MAX_ESPERA = 15,
    parameter int CONT_WIDTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_pronto,
    output logic       mem_req,
    output logic       mem_escrita,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_invalida,
    output logic       erro_mem,
    output logic [2:0] estado
);

    localparam logic [2:0] S_BUSCA      = 3'd0;
    localparam logic [2:0] S_DECODIFICA = 3'd1;
    localparam logic [2:0] S_EXECUTA    = 3'd2;
    localparam logic [2:0] S_MEMORIA    = 3'd3;
    localparam logic [2:0] S_ESCRITA    = 3'd4;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    // Last count value before the watchdog expires.
    localparam logic [CONT_WIDTH-1:0] W_LIMITE = CONT_WIDTH'(MAX_ESPERA - 1);

    logic [2:0]            r_estado;
    logic [CONT_WIDTH-1:0] r_cont;

    logic [2:0]            w_prox;
    logic [CONT_WIDTH-1:0] w_cont_prox;
    logic                  w_acesso;
    logic                  w_estouro;
    logic                  w_op_valida;

    // Watchdog expiry: waiting on memory at the last allowed count, with no completion.
    always_comb begin
        w_acesso    = (r_estado == S_BUSCA) || (r_estado == S_MEMORIA);
        w_estouro   = w_acesso && !mem_pronto && (r_cont == W_LIMITE);
        w_op_valida = (opcode == OP_R)  || (opcode == OP_LW)   || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
    end

    // Output decode and next-state selection; reset forces every output low.
    always_comb begin
        mem_req        = 1'b0;
        mem_escrita    = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = 2'b00;
        alu_src        = 1'b0;
        alu_op         = 2'b00;
        reg_write      = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        instr_invalida = 1'b0;
        erro_mem       = 1'b0;
        estado         = 3'd0;
        w_prox         = S_BUSCA;
        if (!reset) begin
            estado = r_estado;
            case (r_estado)
                S_BUSCA: begin
                    mem_req = 1'b1;
                    if (mem_pronto) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_prox   = S_DECODIFICA;
                    end else if (w_estouro) begin
                        // Fetch timeout: stay in BUSCA and retry with a fresh count.
                        erro_mem = 1'b1;
                    end
                end
                S_DECODIFICA: begin
                    if (w_op_valida) begin
                        w_prox = S_EXECUTA;
                    end else begin
                        instr_invalida = 1'b1;
                    end
                end
                S_EXECUTA: begin
                    case (opcode)
                        OP_R: begin
                            alu_op = 2'b10;
                            w_prox = S_ESCRITA;
                        end
                        OP_ADDI: begin
                            alu_src = 1'b1;
                            w_prox  = S_ESCRITA;
                        end
                        OP_LW, OP_SW: begin
                            alu_src = 1'b1;
                            w_prox  = S_MEMORIA;
                        end
                        OP_BEQ: begin
                            alu_op   = 2'b01;
                            pc_src   = 2'b01;
                            pc_write = zero;
                        end
                        OP_J: begin
                            pc_src   = 2'b10;
                            pc_write = 1'b1;
                        end
                        default: w_prox = S_BUSCA;
                    endcase
                end
                S_MEMORIA: begin
                    mem_req     = 1'b1;
                    alu_src     = 1'b1;
                    mem_escrita = (opcode == OP_SW);
                    if (mem_pronto) begin
                        w_prox = (opcode == OP_LW) ? S_ESCRITA : S_BUSCA;
                    end else if (w_estouro) begin
                        erro_mem = 1'b1;
                    end else begin
                        w_prox = S_MEMORIA;
                    end
                end
                S_ESCRITA: begin
                    reg_write  = 1'b1;
                    reg_dst    = (opcode == OP_R);
                    mem_to_reg = (opcode == OP_LW);
                end
                default: w_prox = S_BUSCA;
            endcase
        end
    end

    // Watchdog count: clears on any state change or expiry, advances while memory stalls.
    always_comb begin
        w_cont_prox = r_cont;
        if ((w_prox != r_estado) || w_estouro) begin
            w_cont_prox = '0;
        end else if (w_acesso && !mem_pronto) begin
            w_cont_prox = r_cont + 1'b1;
        end
    end

    // State and watchdog registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= S_BUSCA;
            r_cont   <= '0;
        end else begin
            r_estado <= w_prox;
            r_cont   <= w_cont_prox;
        end
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: a trace model expands each instruction
// (opcode, zero, fetch wait, memory wait) into the expected per-cycle outputs.
module tb_unidade_controle_multiciclo;

    localparam int MAX_ESPERA = 15;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_pronto;
    logic       mem_req, mem_escrita, ir_write, pc_write, alu_src;
    logic       reg_write, reg_dst, mem_to_reg, instr_invalida, erro_mem;
    logic [1:0] pc_src, alu_op;
    logic [2:0] estado;

    always #5 clock = ~clock;

    unidade_controle_multiciclo #(.MAX_ESPERA(MAX_ESPERA), .CONT_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_pronto(mem_pronto), .mem_req(mem_req), .mem_escrita(mem_escrita),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .instr_invalida(instr_invalida), .erro_mem(erro_mem), .estado(estado)
    );

    typedef struct packed {
        logic [2:0] estado;
        logic       mem_req;
        logic       mem_escrita;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       inv;
        logic       erro;
    } outs_t;

    typedef struct {
        outs_t      o;
        logic       rst;
        logic       pronto;
        logic       zero;
        logic [5:0] op;
    } cyc_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t idle(input logic [2:0] e);
        outs_t o;
        o = '0;
        o.estado = e;
        return o;
    endfunction

    function automatic void push(input outs_t o, input logic p, input logic z,
                                 input logic [5:0] op, input logic r);
        cyc_t c;
        c.o = o; c.pronto = p; c.zero = z; c.op = op; c.rst = r;
        q.push_back(c);
    endfunction

    function automatic bit is_valid(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // Fetch of w stall cycles: every MAX_ESPERA stalled cycles end in one error and a retry.
    function automatic void model_fetch(input int w, input logic [5:0] op);
        outs_t o;
        int    rest;
        rest = w;
        while (rest >= MAX_ESPERA) begin
            for (int i = 0; i < MAX_ESPERA - 1; i++) begin
                o = idle(3'd0); o.mem_req = 1'b1;
                push(o, 1'b0, rb(), op, 1'b0);
            end
            o = idle(3'd0); o.mem_req = 1'b1; o.erro = 1'b1;
            push(o, 1'b0, rb(), op, 1'b0);
            rest -= MAX_ESPERA;
        end
        for (int i = 0; i < rest; i++) begin
            o = idle(3'd0); o.mem_req = 1'b1;
            push(o, 1'b0, rb(), op, 1'b0);
        end
        o = idle(3'd0); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(o, 1'b1, rb(), op, 1'b0);
    endfunction

    function automatic void model_write(input logic rd, input logic m2r, input logic [5:0] op);
        outs_t o;
        o = idle(3'd4); o.reg_write = 1'b1; o.reg_dst = rd; o.mem_to_reg = m2r;
        push(o, rb(), rb(), op, 1'b0);
    endfunction

    // One whole instruction: fetch, decode, execute and, by opcode, memory and write-back.
    function automatic void model_instr(input logic [5:0] op, input logic zb,
                                        input int fw, input int mw);
        outs_t o;
        model_fetch(fw, op);
        o = idle(3'd1);
        if (!is_valid(op)) begin
            o.inv = 1'b1;
            push(o, rb(), rb(), op, 1'b0);
            return;
        end
        push(o, rb(), rb(), op, 1'b0);
        o = idle(3'd2);
        if (op == OP_R) begin
            o.alu_op = 2'b10;
            push(o, rb(), zb, op, 1'b0);
            model_write(1'b1, 1'b0, op);
        end else if (op == OP_ADDI) begin
            o.alu_src = 1'b1;
            push(o, rb(), zb, op, 1'b0);
            model_write(1'b0, 1'b0, op);
        end else if (op == OP_BEQ) begin
            o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_write = zb;
            push(o, rb(), zb, op, 1'b0);
        end else if (op == OP_J) begin
            o.pc_src = 2'b10; o.pc_write = 1'b1;
            push(o, rb(), zb, op, 1'b0);
        end else begin
            o.alu_src = 1'b1;
            push(o, rb(), zb, op, 1'b0);
            o = idle(3'd3); o.mem_req = 1'b1; o.alu_src = 1'b1;
            o.mem_escrita = (op == OP_SW);
            if (mw >= MAX_ESPERA) begin
                for (int i = 0; i < MAX_ESPERA - 1; i++) push(o, 1'b0, rb(), op, 1'b0);
                o.erro = 1'b1;
                push(o, 1'b0, rb(), op, 1'b0);
                return;
            end
            for (int i = 0; i < mw; i++) push(o, 1'b0, rb(), op, 1'b0);
            push(o, 1'b1, rb(), op, 1'b0);
            if (op == OP_LW) model_write(1'b0, 1'b1, op);
        end
    endfunction

    // Apply one cycle of inputs on the falling edge and sample the outputs just after.
    task automatic drive(input cyc_t c, output outs_t obs);
        @(negedge clock);
        reset = c.rst; mem_pronto = c.pronto; zero = c.zero; opcode = c.op;
        #1;
        obs = {estado, mem_req, mem_escrita, ir_write, pc_write, pc_src, alu_src,
               alu_op, reg_write, reg_dst, mem_to_reg, instr_invalida, erro_mem};
    endtask

    task automatic test_reset();
        cyc_t  c;
        outs_t obs;
        int    k = 0;
        q.delete();
        for (int i = 0; i < 3; i++) push('0, 1'b1, rb(), OP_R, 1'b1);
        model_instr(OP_R, 1'b0, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); n_checks++;
            if (obs !== c.o) begin
                n_errors++;
                $display("FAIL reset cyc%0d: got %h required %h", k, obs, c.o);
            end
            k++;
        end
    endtask

    task automatic test_r_type();
        cyc_t  c;
        outs_t obs;
        int    k = 0;
        q.delete();
        model_instr(OP_R, 1'b1, 0, 0);
        model_instr(OP_ADDI, 1'b0, 2, 0);
        model_instr(OP_R, 1'b0, 1, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); n_checks++;
            if (obs !== c.o) begin
                n_errors++;
                $display("FAIL r_type cyc%0d: got %h required %h", k, obs, c.o);
            end
            k++;
        end
    endtask

    task automatic test_lw_wait();
        cyc_t  c;
        outs_t obs;
        int    k = 0;
        q.delete();
        model_instr(OP_LW, 1'b0, 0, 3);
        model_instr(OP_SW, 1'b1, 1, 2);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); n_checks++;
            if (obs !== c.o) begin
                n_errors++;
                $display("FAIL lw_wait cyc%0d: got %h required %h", k, obs, c.o);
            end
            k++;
        end
    endtask

    task automatic test_branch_jump();
        cyc_t  c;
        outs_t obs;
        int    k = 0;
        q.delete();
        model_instr(OP_BEQ, 1'b1, 0, 0);
        model_instr(OP_BEQ, 1'b0, 0, 0);
        model_instr(OP_J, 1'b0, 1, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); n_checks++;
            if (obs !== c.o) begin
                n_errors++;
                $display("FAIL branch_jump cyc%0d: got %h required %h", k, obs, c.o);
            end
            k++;
        end
    endtask

    task automatic test_timeout();
        cyc_t  c;
        outs_t obs;
        int    k = 0;
        q.delete();
        model_instr(OP_SW, 1'b0, 0, MAX_ESPERA);
        model_instr(OP_ADDI, 1'b0, MAX_ESPERA - 1, 0);
        model_instr(OP_LW, 1'b0, MAX_ESPERA, MAX_ESPERA - 1);
        model_instr(OP_R, 1'b0, 10, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); n_checks++;
            if (obs !== c.o) begin
                n_errors++;
                $display("FAIL timeout cyc%0d: got %h required %h", k, obs, c.o);
            end
            k++;
        end
    endtask

    task automatic test_invalid();
        cyc_t       c;
        outs_t      obs;
        int         k = 0;
        logic [5:0] op;
        q.delete();
        model_instr(6'h3F, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            do op = 6'($urandom_range(0, 63)); while (is_valid(op));
            model_instr(op, rb(), int'($urandom_range(0, 2)), 0);
        end
        model_instr(OP_J, 1'b0, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); n_checks++;
            if (obs !== c.o) begin
                n_errors++;
                $display("FAIL invalid cyc%0d: got %h required %h", k, obs, c.o);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid_mem();
        cyc_t  c;
        outs_t obs;
        int    k = 0;
        q.delete();
        // Build an LW with 5 memory waits, then cut it after the second wait.
        model_instr(OP_LW, 1'b0, 0, 5);
        for (int i = 0; i < 5; i++) void'(q.pop_back());
        push('0, 1'b0, rb(), OP_LW, 1'b1);
        model_instr(OP_SW, 1'b0, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); n_checks++;
            if (obs !== c.o) begin
                n_errors++;
                $display("FAIL reset_mid_mem cyc%0d: got %h required %h", k, obs, c.o);
            end
            k++;
        end
    endtask

    task automatic test_random();
        cyc_t       c;
        outs_t      obs;
        int         k = 0;
        int         fw, mw;
        logic [5:0] op;
        logic [5:0] ops [6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        q.delete();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 5)];
            fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
            model_instr(op, rb(), fw, mw);
        end
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); n_checks++;
            if (obs !== c.o) begin
                n_errors++;
                $display("FAIL random cyc%0d op=%h: got %h required %h", k, c.op, obs, c.o);
            end
            k++;
        end
    endtask

    initial begin
        reset = 1'b1; mem_pronto = 1'b0; zero = 1'b0; opcode = 6'h00;
        test_reset();
        test_r_type();
        test_lw_wait();
        test_branch_jump();
        test_timeout();
        test_invalid();
        test_reset_mid_mem();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
